hazard_flush_ctrl: RTL and testbench

HAZARD_FLUSH_CTRL -- requirements
Module: hazard_flush_ctrl

---
 rtl/hazard_flush_ctrl.sv | 134 +++++++++++++
 tb/tb_hazard_flush_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_flush_ctrl.sv
// Pipeline hazard and flush controller for a five-stage in-order core.
// Detects load-use hazards, applies pipeline-wide freezes while data memory
// is busy, and flushes decode for FLUSH_CYCLES cycles after a PC redirect.
// Also keeps saturating counters of stalled cycles and accepted redirects.
module hazard_flush_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [4:0]  id_rs1_addr_in,
  input  logic [4:0]  id_rs2_addr_in,
  input  logic [4:0]  ex_rd_addr_in,
  input  logic        ex_mem_read_in,
  input  logic        redirect_in,
  input  logic        mem_busy_in,
  input  logic        clr_cnt_in,
  output logic        pc_stall_out,
  output logic        if_id_stall_out,
  output logic        id_ex_stall_out,
  output logic        if_id_flush_out,
  output logic        id_ex_flush_out,
  output logic        busy_out,
  output logic [15:0] stall_cnt_out,
  output logic [15:0] redirect_cnt_out
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Value loaded into the flush down counter when a redirect is accepted;
  // the redirect cycle itself is the first flush cycle.
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  state_t      state_q, state_d;
  logic [2:0]  fcnt_q, fcnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] redirect_cnt_q, redirect_cnt_d;
  logic        load_use;
  logic        redirect_accept;

  // A load in execute whose destination feeds the decode instruction;
  // x0 is never a real dependency.
  always_comb begin
    load_use = ex_mem_read_in && (ex_rd_addr_in != 5'd0) &&
               ((ex_rd_addr_in == id_rs1_addr_in) ||
                (ex_rd_addr_in == id_rs2_addr_in));
  end

  // Next-state and control outputs: reset, then memory freeze, then the
  // flush sequence or a new redirect, then load-use bubble insertion.
  always_comb begin
    state_d         = state_q;
    fcnt_d          = fcnt_q;
    redirect_accept = 1'b0;
    pc_stall_out    = 1'b0;
    if_id_stall_out = 1'b0;
    id_ex_stall_out = 1'b0;
    if_id_flush_out = 1'b0;
    id_ex_flush_out = 1'b0;
    busy_out        = 1'b0;

    if (rst_in) begin
      if_id_flush_out = 1'b1;
      id_ex_flush_out = 1'b1;
    end else begin
      busy_out = (state_q == FLUSH);
      if (mem_busy_in) begin
        pc_stall_out    = 1'b1;
        if_id_stall_out = 1'b1;
        id_ex_stall_out = 1'b1;
      end else if (state_q == FLUSH) begin
        if_id_flush_out = 1'b1;
        id_ex_flush_out = 1'b1;
        if (fcnt_q <= 3'd1) begin
          state_d = RUN;
          fcnt_d  = 3'd0;
        end else begin
          fcnt_d = fcnt_q - 3'd1;
        end
      end else if (redirect_in) begin
        if_id_flush_out = 1'b1;
        id_ex_flush_out = 1'b1;
        redirect_accept = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d = FLUSH;
          fcnt_d  = FLUSH_LOAD;
        end
      end else if (load_use) begin
        pc_stall_out    = 1'b1;
        if_id_stall_out = 1'b1;
        id_ex_flush_out = 1'b1;
      end
    end
  end

  // Saturating performance counters; a clear wins over any increment.
  always_comb begin
    stall_cnt_d    = stall_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    if (clr_cnt_in) begin
      stall_cnt_d    = 16'd0;
      redirect_cnt_d = 16'd0;
    end else begin
      if (pc_stall_out && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
      if (redirect_accept && (redirect_cnt_q != CNT_MAX)) begin
        redirect_cnt_d = redirect_cnt_q + 16'd1;
      end
    end
  end

  // State, flush counter and performance counter registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q        <= RUN;
      fcnt_q         <= 3'd0;
      stall_cnt_q    <= 16'd0;
      redirect_cnt_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      fcnt_q         <= fcnt_d;
      stall_cnt_q    <= stall_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign stall_cnt_out    = stall_cnt_q;
  assign redirect_cnt_out = redirect_cnt_q;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Self-checking bench for hazard_flush_ctrl with a three-cycle flush.
// Control outputs are compared as one packed word:
// {pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, busy}.
module tb_hazard_flush_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  exRd;
  logic        memRead;
  logic        redirect;
  logic        memBusy;
  logic        clrCnt;
  logic        pcStall;
  logic        ifIdStall;
  logic        idExStall;
  logic        ifIdFlush;
  logic        idExFlush;
  logic        busy;
  logic [15:0] stallCnt;
  logic [15:0] redirectCnt;

  int checks = 0;
  int passed = 0;

  hazard_flush_ctrl #(.FLUSH_CYCLES(3)) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .id_rs1_addr_in  (rs1),
    .id_rs2_addr_in  (rs2),
    .ex_rd_addr_in   (exRd),
    .ex_mem_read_in  (memRead),
    .redirect_in     (redirect),
    .mem_busy_in     (memBusy),
    .clr_cnt_in      (clrCnt),
    .pc_stall_out    (pcStall),
    .if_id_stall_out (ifIdStall),
    .id_ex_stall_out (idExStall),
    .if_id_flush_out (ifIdFlush),
    .id_ex_flush_out (idExFlush),
    .busy_out        (busy),
    .stall_cnt_out   (stallCnt),
    .redirect_cnt_out(redirectCnt)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       mr;
    logic       redir;
    logic       busy;
    logic [5:0] ctl;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [5:0] ctlNow();
    return {pcStall, ifIdStall, idExStall, ifIdFlush, idExFlush, busy};
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual === expected) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] r1, input logic [4:0] r2,
                               input logic [4:0] rd, input logic mr,
                               input logic redir, input logic bz,
                               input logic clr);
    rs1      = r1;
    rs2      = r2;
    exRd     = rd;
    memRead  = mr;
    redirect = redir;
    memBusy  = bz;
    clrCnt   = clr;
  endtask

  task automatic idle();
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Check control outputs mid-cycle, then advance to just after the next edge
  task automatic cycleCheck(input string name, input logic [5:0] expCtl);
    #3;
    checkOutput(name, {10'd0, ctlNow()}, {10'd0, expCtl});
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 6'b000000};
    vecs[1]  = '{5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 6'b110010};
    vecs[2]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 6'b000000};
    vecs[3]  = '{5'd9, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 6'b110010};
    vecs[4]  = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 6'b000000};
    vecs[5]  = '{5'd3, 5'd4, 5'd7, 1'b1, 1'b0, 1'b0, 6'b000000};
    vecs[6]  = '{5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 6'b000000};
    vecs[7]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 6'b000110};
    vecs[8]  = '{5'd6, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0, 6'b000111};
    vecs[9]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 6'b000111};
    vecs[10] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 6'b000000};

    rst = 1'b1;
    idle();
    #2;
    checkOutput("reset.ctl", {10'd0, ctlNow()}, {10'd0, 6'b000110});
    checkOutput("reset.stallCnt", stallCnt, 16'd0);
    checkOutput("reset.redirectCnt", redirectCnt, 16'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table: load-use, x0, mismatch, redirect with ignored events in FLUSH
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].mr,
                    vecs[i].redir, vecs[i].busy, 1'b0);
      cycleCheck($sformatf("vec%0d", i), vecs[i].ctl);
    end
    checkOutput("table.stallCnt", stallCnt, 16'd2);
    checkOutput("table.redirectCnt", redirectCnt, 16'd1);

    // Freeze while FLUSH has one cycle left
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycleCheck("A.redirect", 6'b000110);
    idle();
    cycleCheck("A.flush1", 6'b000111);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycleCheck($sformatf("A.freeze%0d", i), 6'b111001);
    end
    idle();
    cycleCheck("A.flushLast", 6'b000111);
    cycleCheck("A.run", 6'b000000);
    checkOutput("A.stallCnt", stallCnt, 16'd6);
    checkOutput("A.redirectCnt", redirectCnt, 16'd2);

    // Busy, redirect and load-use together, then redirect wins
    applyStimulus(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    cycleCheck("B.allEvents", 6'b111000);
    checkOutput("B.freezeStallCnt", stallCnt, 16'd7);
    checkOutput("B.freezeRedirectCnt", redirectCnt, 16'd2);
    applyStimulus(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    cycleCheck("B.redirectWins", 6'b000110);
    checkOutput("B.redirectCnt", redirectCnt, 16'd3);
    idle();
    cycleCheck("B.flush2", 6'b000111);
    cycleCheck("B.flush3", 6'b000111);
    cycleCheck("B.run", 6'b000000);

    // Clear overrides a same-cycle stall increment
    applyStimulus(5'd0, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
    cycleCheck("C.loadUseClr", 6'b110010);
    checkOutput("C.stallCnt", stallCnt, 16'd0);
    checkOutput("C.redirectCnt", redirectCnt, 16'd0);
    idle();
    cycleCheck("C.idle", 6'b000000);

    // Stall counter saturation
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (65534) @(posedge clk);
    #1;
    checkOutput("D.preload", stallCnt, 16'hFFFE);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("D.saturate", stallCnt, 16'hFFFF);
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycleCheck("D.clr", 6'b000000);
    checkOutput("D.cleared", stallCnt, 16'd0);
    idle();

    // Reset in the middle of a flush
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycleCheck("E.redirect", 6'b000110);
    idle();
    #1;
    checkOutput("E.inFlush", {10'd0, ctlNow()}, {10'd0, 6'b000111});
    checkOutput("E.redirectCnt", redirectCnt, 16'd1);
    rst = 1'b1;
    #1;
    checkOutput("E.resetCtl", {10'd0, ctlNow()}, {10'd0, 6'b000110});
    checkOutput("E.resetRedirectCnt", redirectCnt, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycleCheck("E.runAfterReset", 6'b000000);
    applyStimulus(5'd2, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    cycleCheck("E.loadUseAfterReset", 6'b110010);
    checkOutput("E.stallCnt", stallCnt, 16'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
